klotski_shuffle: RTL



---
 rtl/klotski_pkg.sv | 57 +++++
 rtl/klotski_shuffle_if.sv | 24 ++
 rtl/klotski_lfsr16.sv | 27 ++
 rtl/klotski_shuffle.sv | 126 ++++++++++++
 4 files changed

// File: rtl/klotski_pkg.sv
// Shared types and helpers for the sliding-puzzle datapath (scrambler and solvers).
// Board cells are indexed [row][col] with row 0 at the top; value 0 is the blank.
package klotski_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef logic [0:3][0:3][3:0] board_t;
  typedef logic [0:1][1:0]      pos_t;   // {row, col}

  typedef enum logic [1:0] {
    S_IDLE,
    S_PICK,
    S_MOVE,
    S_FINISH
  } shuffle_state_t;

  localparam board_t SOLVED_BOARD = {
    4'd1,  4'd2,  4'd3,  4'd4,
    4'd5,  4'd6,  4'd7,  4'd8,
    4'd9,  4'd10, 4'd11, 4'd12,
    4'd13, 4'd14, 4'd15, 4'd0
  };
  localparam pos_t        BLANK_HOME = {2'd3, 2'd3};
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  // UP/DOWN and LEFT/RIGHT differ only in bit 0.
  function automatic dir_t dir_reverse(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

  function automatic logic dir_in_bounds(input pos_t z, input dir_t d);
    case (d)
      UP:      return z[0] != 2'd0;
      DOWN:    return z[0] != 2'd3;
      LEFT:    return z[1] != 2'd0;
      default: return z[1] != 2'd3;
    endcase
  endfunction

  function automatic pos_t pos_step(input pos_t z, input dir_t d);
    pos_t n;
    n = z;
    case (d)
      UP:      n[0] = z[0] - 2'd1;
      DOWN:    n[0] = z[0] + 2'd1;
      LEFT:    n[1] = z[1] - 2'd1;
      default: n[1] = z[1] + 2'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/klotski_shuffle_if.sv
// Control and result bundle of the scrambler; master drives the request, slave is the scrambler.
interface klotski_shuffle_if #(
  parameter int unsigned STEPS_W = 8
);
  logic                  i_start;
  logic [15:0]           i_seed;
  logic [STEPS_W-1:0]    i_steps;
  logic [3:0][3:0][3:0]  o_klotski;
  logic [3:0]            o_zero_pos;
  logic                  o_move_valid;
  logic [1:0]            o_move_dir;
  logic                  o_busy;
  logic                  o_finished;

  modport master (
    output i_start, i_seed, i_steps,
    input  o_klotski, o_zero_pos, o_move_valid, o_move_dir, o_busy, o_finished
  );

  modport slave (
    input  i_start, i_seed, i_steps,
    output o_klotski, o_zero_pos, o_move_valid, o_move_dir, o_busy, o_finished
  );
endinterface

// File: rtl/klotski_lfsr16.sv
// 16-bit Galois shift-right LFSR; a zero seed is replaced by SEED_DEFAULT so it never locks up.
module klotski_lfsr16
  import klotski_pkg::*;
#(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  input  logic        i_adv,
  output logic [15:0] o_lfsr
);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_lfsr <= '0;
    end else if (i_load) begin
      o_lfsr <= (i_seed == 16'h0000) ? SEED_DEFAULT : i_seed;
    end else if (i_adv) begin
      o_lfsr <= o_lfsr[0] ? ((o_lfsr >> 1) ^ LFSR_TAPS) : (o_lfsr >> 1);
    end
  end

endmodule

// File: rtl/klotski_shuffle.sv
// Scrambles a solved 4x4 board by walking the blank N pseudo-random legal steps,
// streaming each move out so the scramble can be replayed downstream.
module klotski_shuffle
  import klotski_pkg::*;
#(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
  parameter int unsigned STEPS_W      = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  klotski_shuffle_if.slave   bus
);

  shuffle_state_t      state_q, state_d;
  board_t              board_q;
  pos_t                zero_q, zero_nb;
  dir_t                dir_q, prev_q, move_dir_q, pick_dir;
  logic                prev_valid_q;
  logic [STEPS_W-1:0]  count_q;
  logic [1:0]          cand_bits;
  logic [13:0]         lfsr_unused;
  logic                start_ok;
  logic                move_valid_q, finished_q, busy_q;

  assign start_ok = (state_q == S_IDLE) && bus.i_start;

  klotski_lfsr16 #(.SEED_DEFAULT(SEED_DEFAULT)) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (start_ok),
    .i_seed  (bus.i_seed),
    .i_adv   (state_q == S_PICK),
    .o_lfsr  ({lfsr_unused, cand_bits})
  );

  // Rotate-priority pick: scanning from candidate+3 down to candidate leaves the
  // lowest-offset legal direction as the final assignment.
  function automatic dir_t pick_first_legal(input logic [1:0] base, input pos_t z,
                                            input logic pv, input dir_t prev);
    dir_t cand, pick;
    pick = dir_t'(base);
    for (int i = 3; i >= 0; i--) begin
      cand = dir_t'(base + 2'(i));
      if (dir_in_bounds(z, cand) && !(pv && (cand == dir_reverse(prev)))) pick = cand;
    end
    return pick;
  endfunction

  assign pick_dir = pick_first_legal(cand_bits, zero_q, prev_valid_q, prev_q);
  assign zero_nb  = pos_step(zero_q, dir_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets its hold value before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.i_start) state_d = (bus.i_steps == '0) ? S_FINISH : S_PICK;
      S_PICK:   state_d = S_MOVE;
      S_MOVE:   state_d = (count_q == STEPS_W'(1)) ? S_FINISH : S_PICK;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: the 16-cell board sits in flops, not RAM, so it takes the async reset
  // like any other register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      board_q      <= '0;
      zero_q       <= '0;
      dir_q        <= UP;
      prev_q       <= UP;
      move_dir_q   <= UP;
      prev_valid_q <= 1'b0;
      count_q      <= '0;
      move_valid_q <= 1'b0;
      finished_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      move_valid_q <= 1'b0;
      finished_q   <= (state_q == S_FINISH);
      // Busy stays up through the done pulse and drops the cycle after.
      busy_q       <= (state_q != S_IDLE) || bus.i_start;
      unique case (state_q)
        S_IDLE: begin
          if (bus.i_start) begin
            board_q      <= SOLVED_BOARD;
            zero_q       <= BLANK_HOME;
            count_q      <= bus.i_steps;
            prev_valid_q <= 1'b0;
          end
        end
        S_PICK: dir_q <= pick_dir;
        S_MOVE: begin
          board_q[zero_q[0]][zero_q[1]]   <= board_q[zero_nb[0]][zero_nb[1]];
          board_q[zero_nb[0]][zero_nb[1]] <= 4'd0;
          zero_q       <= zero_nb;
          prev_q       <= dir_q;
          prev_valid_q <= 1'b1;
          count_q      <= count_q - STEPS_W'(1);
          move_valid_q <= 1'b1;
          move_dir_q   <= dir_q;
        end
        default: ;
      endcase
    end
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign bus.o_klotski[r][c] = board_q[r][c];
    end
  end

  assign bus.o_zero_pos   = zero_q;
  assign bus.o_move_valid = move_valid_q;
  assign bus.o_move_dir   = move_dir_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_finished   = finished_q;

endmodule
